uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver that is the receive-side companion to the existing `uart` transmitter. It samples an external serial line at 16x the baud rate, recovers 8N1 frames (LSB first), and presents each byte in a one-entry holding register with a valid/read handshake. The block sits in the I/O peripheral space next to `uart`, so the core can read host input in simulation and on the board. Baud and system clock come from `define.vh` (`` `BAUD_RATE``, `` `SYSCLK_FREQ``), the same source the transmitter uses.

## Interface
- OVERSAMPLE, 16, sample ticks per bit; fixed at 16 for this release.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_rx  in  1  serial line; idle high; asynchronous to clk
- rd_en  in  1  consume the held byte; ignored while rd_valid=0
- rd_data  out  8  last received byte; reset 8'h00
- rd_valid  out  1  a byte is held and unread; reset 0
- frame_err  out  1  one-cycle pulse when the stop bit samples low; reset 0
- overrun  out  1  sticky; a byte was overwritten before being read; reset 0

## Operation
- **Input synchronizer:** uart_rx passes through 2 flops, each reset to 1, to produce rx_s. All decisions use rx_s only.
- **Tick generator:** 32-bit phase accumulator.
  - Every cycle: acc += `` `BAUD_RATE``*16.
  - When the sum is >= `` `SYSCLK_FREQ``: subtract `` `SYSCLK_FREQ`` and assert tick for 1 cycle.
  - Constraint: `` `BAUD_RATE``*16 < `` `SYSCLK_FREQ``. acc resets to 0.
- **FSM states:** IDLE, START, DATA, STOP. Registers: 4-bit tick count cnt, 3-bit bit index bidx, 8-bit shift register sh.
  - IDLE: on tick with rx_s=0, go to START with cnt=0.
  - START: on tick, cnt++. When cnt reaches 7 (mid start bit): if rx_s=0, go to DATA with cnt=0, bidx=0. Otherwise it is a glitch; return to IDLE.
  - DATA: on tick, cnt++. At cnt=15: shift right with sh={rx_s,sh[7:1]}, then bidx++. After bidx=7 is sampled, go to STOP with cnt=0.
  - STOP: on tick, cnt++. At cnt=15 (mid stop bit):
    - rx_s=1: load rd_data<=sh and set rd_valid<=1.
    - rx_s=0: pulse frame_err; discard the byte, leaving rd_data and rd_valid unchanged.
    - Either way, go to IDLE. The early return gives half a bit of resync margin.
- **Holding register:**
  - rd_en with rd_valid=1: clears rd_valid and overrun.
  - Frame completes while rd_valid=1 and rd_en=0: overwrite rd_data, keep rd_valid=1, set overrun=1.
  - Frame completes in the same cycle as rd_en: load the new byte, rd_valid stays 1, overrun is not set.
- A low line held past START (break condition) produces a frame_err. The FSM then re-arms only after rx_s goes high and then falls again. IDLE must therefore also require that rx_s was seen high since the last frame.
- **Reset mid-frame:** everything returns to reset values immediately. No partial byte is ever delivered.

## Timing
- Latency: rd_valid rises 1 clk after the tick at mid stop bit, i.e. ~9.5 bit times after the start-bit falling edge, plus 2-3 clk for synchronizer and tick quantization.
- Sampling jitter is at most 1/16 bit. Tolerated baud mismatch is about ±4%.
- rd_data is stable whenever rd_valid=1 and no new frame is completing.
- frame_err is exactly 1 clk wide. overrun is level-sensitive.

## Structure
- Add `` `UART_OVERSAMPLE`` to `define.vh` next to `` `BAUD_RATE``/`` `SYSCLK_FREQ``. Add the FSM state encodings as localparams in `define.vh`, so that `uart` can adopt them later.
- One sub-module: `uart_tick_gen` (accumulator plus tick output), parameterized by multiplier. It is reusable by `uart` if it is later moved to 16x.
- Everything else lives in `uart_rx`.

## Test plan
- Loopback `uart` → `uart_rx` at `` `SYSCLK_FREQ``=50_000_000, `` `BAUD_RATE``=115200. Write 8'hA5 → rd_valid=1 with rd_data=8'hA5 within 11 bit times, frame_err=0. Then rd_en → rd_valid=0.
- Back-to-back bytes 8'h00, 8'hFF, 8'h55 with an rd_en after each → three correct bytes, overrun stays 0.
- Inject a 1/4-bit low glitch on an idle line → FSM returns to IDLE, no rd_valid, no frame_err.
- Drive a frame 8'h3C with the stop bit low → frame_err pulses 1 clk, rd_valid stays 0, next valid frame 8'h81 is received correctly.
- Send 8'h11 and then 8'h22 without rd_en → rd_data=8'h22, overrun=1, rd_valid=1. A single rd_en clears both flags. Also assert rd_en in the exact cycle a new frame completes → new byte held, overrun=0.
- Assert rst_n=0 during data bit 4 → all outputs return to reset values. Release, send 8'h7E → received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared constants and types for the 16x-oversampled UART receiver.
//   Default baud / system clock match the values used by the uart
//   transmitter. The FSM encoding lives here so uart can adopt it later.
package uart_rx_pkg;

  // Sample ticks per bit; fixed for this release.
  localparam int unsigned UART_OVERSAMPLE = 16;

  localparam int unsigned DEF_SYSCLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE   = 115_200;

  // Tick count at which the start bit is re-checked (middle of the bit).
  localparam logic [3:0] MID_START_CNT = 4'd7;
  // Tick count at which data and stop bits are sampled.
  localparam logic [3:0] LAST_TICK_CNT = 4'd15;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Serial line plus holding-register handshake of the UART receiver.
//   uart_rx   : serial line, idle high, asynchronous to the system clock
//   rd_en     : consume the held byte (ignored while rd_valid=0)
//   rd_data   : last received byte
//   rd_valid  : a byte is held and unread
//   frame_err : one-cycle pulse when a stop bit samples low
//   overrun   : sticky, a held byte was overwritten before being read
//   master = host side (drives line and rd_en), slave = receiver.
interface uart_rx_if;
  logic       uart_rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overrun;

  modport master (
    output uart_rx,
    output rd_en,
    input  rd_data,
    input  rd_valid,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  uart_rx,
    input  rd_en,
    output rd_data,
    output rd_valid,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/uart_tick_gen.sv
// uart_tick_gen
//   Phase-accumulator tick generator. Produces a one-cycle tick at an
//   average rate of BAUD*MULT per second from a CLK_FREQ clock.
//   Requires BAUD*MULT < CLK_FREQ.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (accumulator clears to 0)
//   tick_o : one-cycle pulse per oversample period
module uart_tick_gen #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned MULT     = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  // One extra bit so the sum cannot wrap before the compare.
  localparam logic [32:0] INC  = 33'(BAUD * MULT);
  localparam logic [32:0] STEP = 33'(CLK_FREQ);

  logic [31:0] acc_q, acc_d;
  logic        tick_q, tick_d;
  logic [32:0] sum;

  always_comb begin
    sum    = {1'b0, acc_q} + INC;
    acc_d  = sum[31:0];
    tick_d = 1'b0;
    if (sum >= STEP) begin
      acc_d  = 32'(sum - STEP);
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 UART receiver, LSB first, sampling the line at 16x the baud rate.
//   Each received byte lands in a one-entry holding register read with a
//   valid/read handshake.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   rx_bus : uart_rx_if slave (serial line in, holding register out)
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned SYSCLK_FREQ = DEF_SYSCLK_FREQ,
  parameter int unsigned BAUD_RATE   = DEF_BAUD_RATE
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  rx_bus
);

  // Two-flop synchronizer; reset high so a reset does not look like a start.
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[0], rx_bus.uart_rx};
  end

  assign rx_s = sync_q[1];

  logic tick;

  uart_tick_gen #(
    .CLK_FREQ (SYSCLK_FREQ),
    .BAUD     (BAUD_RATE),
    .MULT     (UART_OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // Frame FSM and its datapath.
  rx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] sh_q, sh_d;
  // Line seen high since the last frame ended; blocks re-triggering on a
  // line held low (break) after its frame error.
  logic       armed_q, armed_d;
  logic       load_evt;
  logic       ferr_evt;

  // Holding register.
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bidx_q      <= '0;
      sh_q        <= '0;
      armed_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      sh_q        <= sh_d;
      armed_q     <= armed_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bidx_d   = bidx_q;
    sh_d     = sh_q;
    armed_d  = armed_q;
    load_evt = 1'b0;
    ferr_evt = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (rx_s) armed_d = 1'b1;
        if (tick && !rx_s && armed_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end

      RX_START: begin
        if (tick) begin
          if (cnt_q == MID_START_CNT) begin
            if (!rx_s) begin
              state_d = RX_DATA;
              cnt_d   = '0;
              bidx_d  = '0;
            end else begin
              // Start bit did not survive to mid-bit: glitch.
              state_d = RX_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      RX_DATA: begin
        if (tick) begin
          if (cnt_q == LAST_TICK_CNT) begin
            sh_d  = {rx_s, sh_q[7:1]};
            cnt_d = '0;
            if (bidx_q == 3'd7) state_d = RX_STOP;
            else                bidx_d  = bidx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      RX_STOP: begin
        if (tick) begin
          if (cnt_q == LAST_TICK_CNT) begin
            // Leaving at mid stop bit leaves half a bit of resync margin.
            if (rx_s) load_evt = 1'b1;
            else      ferr_evt = 1'b1;
            state_d = RX_IDLE;
            cnt_d   = '0;
            armed_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  // Output logic: holding register and status flags.
  always_comb begin
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = ferr_evt;

    if (rx_bus.rd_en && rd_valid_q) begin
      rd_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    // A completing frame wins over a read in the same cycle; overrun only
    // when the held byte is lost without having been read.
    if (load_evt) begin
      rd_data_d  = sh_q;
      rd_valid_d = 1'b1;
      if (rd_valid_q && !rx_bus.rd_en) overrun_d = 1'b1;
    end
  end

  assign rx_bus.rd_data   = rd_data_q;
  assign rx_bus.rd_valid  = rd_valid_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.overrun   = overrun_q;

endmodule
